stage_f: RTL
============

// Module: stage_f
// PURPOSE
//   Fetch stage of the P8 MIPS pipeline; sits directly upstream of the F/D pipeline register (StageD).
//   - Owns the architectural fetch PC and drives the instruction-memory address.
//   - Selects the next PC from: exception entry, eret redirect, branch/jump redirect, sequential PC+4.
//   - Tags every fetched word with its PC, a fetch exception code and a delay-slot flag.
// PARAMETERS
//   RESET_PC   32'h0000_3000  PC loaded on reset
//   HANDLER_PC 32'h0000_4180  PC loaded on exception request
//   IM_LO      32'h0000_3000  lowest legal fetch address (inclusive)
//   IM_HI      32'h0000_6FFC  highest legal fetch address (inclusive)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous reset, active-low
//   stall      in   1   hazard stall; holds the PC (same signal that stalls StageD)
//   req        in   1   exception/interrupt entry from CP0
//   eret       in   1   eret in D; redirects fetch to epc (same cycle StageD is flushed)
//   epc        in   32  CP0 EPC value, valid while eret=1
//   br_taken   in   1   branch/jump in D resolved taken
//   br_target  in   32  redirect address, valid while br_taken=1
//   d_is_jump  in   1   instruction currently in D is a branch/jump
//   im_addr    out  32  instruction-memory address (= pc)
//   im_rdata   in   32  instruction word, combinational read of im_addr
//   instr_out  out  32  fetched word to StageD (0 when exc_out != 0)
//   pc_out     out  32  PC of instr_out
//   exc_out    out  5   fetch exception code: 0 none, 5'd4 AdEL
//   slot_out   out  1   instr_out is a delay-slot instruction
//   jumpto     out  32  eret redirect PC to StageD (= epc)
// BEHAVIOUR
//   - State: pc register (32b). Reset (rst=0, async): pc=RESET_PC; outputs follow combinationally:
//     pc_out=RESET_PC, exc_out=0, slot_out=d_is_jump, instr_out=im_rdata.
//   - Next-PC priority each rising edge: req > stall > eret > br_taken > pc+4.
//     req: pc<=HANDLER_PC (overrides stall). stall: pc held, all outputs stable.
//     eret: pc<=epc. br_taken: pc<=br_target (word now fetched is the delay slot, not squashed).
//   - pc+4 wraps modulo 2^32; no carry out.
//   - Fetch latency: zero cycles (combinational im); instruction enters D one edge later via StageD.
//   - exc_out=5'd4 when pc[1:0]!=0 or pc outside [IM_LO,IM_HI]; then instr_out=0 and im_addr
//     is still driven = pc (memory must tolerate it); pc_out=pc regardless.
//   - slot_out = d_is_jump & ~eret (eret has no delay slot).
//   - Simultaneous req+eret or req+br_taken: req wins. eret+br_taken: eret wins.
//   - Reset asserted mid-stall or mid-redirect: pc=RESET_PC immediately; pending redirect is lost.
//   - jumpto=epc combinationally; StageD uses it only on flush.
// CONFIGURATION
//   FETCH_RANGE_CHECK_EN defined: AdEL on misalignment OR out-of-range pc (as above).
//   Not defined: AdEL on misalignment only; range comparators removed, IM_LO/IM_HI unused.
// STRUCTURE
//   Shared package/header: EXC_NONE=5'd0, EXC_ADEL=5'd4, RESET_PC/HANDLER_PC defaults
//   (also used by StageD and CP0).
//   Sub-module: fetch_npc (pure combinational next-PC priority mux); pc register and exception
//   tagging stay in stage_f.
// TESTING
//   1 reset release, no stall, 4 cycles -> pc_out 3000,3004,3008,300C; exc_out=0; slot_out=0.
//   2 br_taken=1, br_target=3100 at pc=3008, d_is_jump=1 -> pc_out=3008 slot_out=1; next pc_out=3100.
//   3 stall=1 for 3 cycles at pc=3010 with br_taken=1 -> pc_out stays 3010; after release next=target.
//   4 req=1 with stall=1 at pc=3020 -> next pc_out=4180 exc_out=0; req+eret same cycle -> 4180.
//   5 eret=1, epc=3002 -> next pc_out=3002 exc_out=4 instr_out=0 slot_out=0; jumpto=3002.
//   6 br_target=7000 -> exc_out=4 with FETCH_RANGE_CHECK_EN, exc_out=0 without; rst low mid-run -> 3000.

Source files
------------

// File: rtl/stage_f_pkg.sv
// Shared fetch definitions for the P8 pipeline (used by StageF, StageD and CP0).
//   - Exception codes carried down the pipe (EXC_NONE, EXC_ADEL).
//   - Default reset / exception-handler PCs and the legal instruction window.
//   - The fetch bundle handed to the F/D register, plus small PC helpers.
package stage_f_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned PC_STEP = 4;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [XLEN-1:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_LO_DEFAULT      = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_HI_DEFAULT      = 32'h0000_6FFC;

  // Payload presented to the F/D pipeline register.
  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [EXC_W-1:0] exc;
    logic             slot;
  } fetch_bundle_t;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_seq(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_STEP);
  endfunction

  // Instruction fetches must be word aligned.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/stage_f_fetch_npc.sv
// fetch_npc: pure combinational next-PC selection for the fetch stage.
// Priority (highest first): req > stall > eret > br_taken > pc+4.
// Ports:
//   pc_i         current fetch PC
//   req_i        exception/interrupt entry -> handler_pc_i (beats stall)
//   stall_i      hold the current PC
//   eret_i       return-from-exception -> epc_i
//   epc_i        CP0 EPC
//   br_taken_i   branch/jump resolved taken -> br_target_i
//   br_target_i  branch/jump target
//   handler_pc_i exception vector
//   npc_o        PC to load on the next rising edge
module fetch_npc
  import stage_f_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            req_i,
  input  logic            stall_i,
  input  logic            eret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [XLEN-1:0] handler_pc_i,
  output logic [XLEN-1:0] npc_o
);

  // Priority chain; the default is the sequential successor.
  always_comb begin
    npc_o = pc_seq(pc_i);
    if (req_i) begin
      npc_o = handler_pc_i;
    end else if (stall_i) begin
      npc_o = pc_i;
    end else if (eret_i) begin
      npc_o = epc_i;
    end else if (br_taken_i) begin
      npc_o = br_target_i;
    end
  end

endmodule

// File: rtl/stage_f.sv
// stage_f: fetch stage of the P8 MIPS pipeline, directly upstream of StageD.
// Owns the fetch PC, drives the instruction-memory address and tags each
// fetched word with its PC, an address-error code and a delay-slot flag.
// Build option: define FETCH_RANGE_CHECK_EN to also raise AdEL when the PC
// falls outside [IM_LO, IM_HI]; otherwise only misalignment raises AdEL.
// Ports:
//   clk, rst          clock / asynchronous active-low reset
//   stall             hold the PC (shared with StageD)
//   req               exception entry from CP0 (overrides stall)
//   eret, epc         eret in D and its return address
//   br_taken,br_target resolved branch/jump redirect
//   d_is_jump         instruction in D is a branch/jump
//   im_addr, im_rdata instruction memory address / combinational read data
//   instr_out, pc_out, exc_out, slot_out   fetch bundle to StageD
//   jumpto            eret redirect PC for StageD's flush path
module stage_f
  import stage_f_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [XLEN-1:0] IM_LO      = IM_LO_DEFAULT,
  parameter logic [XLEN-1:0] IM_HI      = IM_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             req,
  input  logic             eret,
  input  logic [XLEN-1:0]  epc,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_target,
  input  logic             d_is_jump,
  output logic [XLEN-1:0]  im_addr,
  input  logic [XLEN-1:0]  im_rdata,
  output logic [XLEN-1:0]  instr_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [EXC_W-1:0] exc_out,
  output logic             slot_out,
  output logic [XLEN-1:0]  jumpto
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            out_of_range;
  logic            adel;
  fetch_bundle_t   bundle;

  // Next-PC priority mux.
  fetch_npc u_npc (
    .pc_i         (pc_q),
    .req_i        (req),
    .stall_i      (stall),
    .eret_i       (eret),
    .epc_i        (epc),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .handler_pc_i (HANDLER_PC),
    .npc_o        (pc_d)
  );

  // Fetch PC register; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_RANGE_CHECK_EN
  // Legal instruction window, both bounds inclusive.
  assign out_of_range = (pc_q < IM_LO) || (pc_q > IM_HI);
`else
  logic unused_im_window;
  assign unused_im_window = ^{IM_LO, IM_HI};
  assign out_of_range     = 1'b0;
`endif

  assign adel = pc_misaligned(pc_q) || out_of_range;

  // Faulting fetches still address memory but hand StageD a zero word.
  always_comb begin
    bundle.pc    = pc_q;
    bundle.exc   = adel ? EXC_ADEL : EXC_NONE;
    bundle.instr = adel ? '0 : im_rdata;
    bundle.slot  = d_is_jump & ~eret;  // eret has no delay slot
  end

  assign im_addr   = pc_q;
  assign instr_out = bundle.instr;
  assign pc_out    = bundle.pc;
  assign exc_out   = bundle.exc;
  assign slot_out  = bundle.slot;
  assign jumpto    = epc;

endmodule
